// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: hazard/branch control in, instruction memory port,
// and the IF/ID register outputs toward decode.
// With FETCH_PERF_CNT_EN defined the bus also carries the fetch and
// stall performance counters.
interface if_fetch_unit_if;
  // control from hazard unit / ID stage
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  // instruction memory (combinational response)
  logic [31:0] rom_data_i;
  logic [31:0] pc_o;
  logic        ce_o;
  // IF/ID register
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;

  modport slave (
    input  stall_i, flush_i, flush_addr_i, branch_flag_i,
           branch_target_addr_i, rom_data_i,
    output pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o,
           fetch_cnt_o, stall_cnt_o
  );
  modport master (
    output stall_i, flush_i, flush_addr_i, branch_flag_i,
           branch_target_addr_i, rom_data_i,
    input  pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o,
           fetch_cnt_o, stall_cnt_o
  );
`else
  modport slave (
    input  stall_i, flush_i, flush_addr_i, branch_flag_i,
           branch_target_addr_i, rom_data_i,
    output pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o
  );
  modport master (
    output stall_i, flush_i, flush_addr_i, branch_flag_i,
           branch_target_addr_i, rom_data_i,
    input  pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o
  );
`endif
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, memory chip enable and the IF/ID
// pipeline register. Priority per edge once fetching: flush > stall >
// branch > sequential (+4, modulo 2^32).
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t      state_q, state_d;
  logic        ce;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        capture_valid;

  // fetch-enable state register; leaving reset always costs one warm-up edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state: IDLE lasts exactly one edge, FETCH holds until reset
  always_comb begin
    state_d = S_FETCH;
    ce      = 1'b0;
    case (state_q)
      S_IDLE:  begin state_d = S_FETCH; ce = 1'b0; end
      S_FETCH: begin state_d = S_FETCH; ce = 1'b1; end
      default: begin state_d = S_IDLE;  ce = 1'b0; end
    endcase
  end

  // next PC and IF/ID contents, resolved in priority order
  always_comb begin
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    capture_valid = 1'b0;
    if (!ce) begin
      // warm-up: PC parked, decode sees a bubble
      pc_d       = RESET_PC;
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (bus.flush_i) begin
      // flush beats a concurrent stall; the stall is dropped, not deferred
      pc_d       = bus.flush_addr_i;
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (bus.stall_i) begin
      // hold everything; branch_flag_i is re-presented after the stall
      pc_d = pc_q;
    end else begin
      // branch and sequential both capture the current word; the branch
      // only changes where the next fetch comes from (delay slot kept)
      pc_d          = bus.branch_flag_i ? bus.branch_target_addr_i
                                        : pc_q + 32'd4;
      id_pc_d       = pc_q;
      id_inst_d     = bus.rom_data_i;
      id_valid_d    = 1'b1;
      capture_valid = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_WORD;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.ce_o       = ce;
  assign bus.id_pc_o    = id_pc_q;
  assign bus.id_inst_o  = id_inst_q;
  assign bus.id_valid_o = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_evt;

  assign stall_evt = ce & bus.stall_i & ~bus.flush_i;

  // performance counters, free-running modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (capture_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;
`endif

endmodule
